snake_segment_arbiter: RTL

- Owns the snake segment RAM, which stores one {x,y} entry per segment index.
- Shares that single-ported RAM between three masters:
  - the game-logic writer (body shift and grow),
  - the game-logic collision scanner (reader),
  - the VGA renderer's segment query (reader).
- Performs one RAM operation per cycle and returns read data with fixed latency, so the renderer's frame-buffer fill and the game tick can overlap safely.

---
 rtl/snake_segment_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/snake_segment_arbiter.sv
// Snake segment RAM with a three-master arbiter (writer, game reader, VGA reader).
// Optional stall statistics counter is enabled by defining SNAKE_ARB_STATS_EN.
module snake_segment_arbiter #(
  parameter int unsigned X_BITS     = 6,
  parameter int unsigned Y_BITS     = 6,
  parameter int unsigned S_ADDR_W   = 8,
  parameter int unsigned S_LEN_W    = 8,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                sys_clk,
  input  logic                sys_reset,
  input  logic [S_LEN_W-1:0]  snake_length_in,
  input  logic                wr_req,
  input  logic [S_ADDR_W-1:0] wr_addr,
  input  logic [X_BITS-1:0]   wr_x,
  input  logic [Y_BITS-1:0]   wr_y,
  output logic                wr_gnt,
  input  logic                game_rd_req,
  input  logic [S_ADDR_W-1:0] game_rd_addr,
  output logic                game_rd_gnt,
  output logic                game_rd_valid,
  output logic [X_BITS-1:0]   game_rd_x,
  output logic [Y_BITS-1:0]   game_rd_y,
  output logic                game_rd_seg_valid,
  input  logic                vga_rd_req,
  input  logic [S_ADDR_W-1:0] vga_rd_addr,
  output logic                vga_rd_gnt,
  output logic                vga_rd_valid,
  output logic [X_BITS-1:0]   vga_rd_x,
  output logic [Y_BITS-1:0]   vga_rd_y,
  output logic                vga_rd_seg_valid
`ifdef SNAKE_ARB_STATS_EN
  ,
  output logic [15:0]         stall_cnt_out,
  input  logic                stall_cnt_clr
`endif
);

  localparam int unsigned DataW = X_BITS + Y_BITS;
  localparam int unsigned Depth = 2 ** S_ADDR_W;
  localparam int unsigned CmpW  = (S_ADDR_W > S_LEN_W) ? S_ADDR_W : S_LEN_W;
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [DataW-1:0]    mem [Depth];
  logic [3:0]          game_wait_q, game_wait_d, vga_wait_q, vga_wait_d;
  logic                rr_q, rr_d;  // 0: game reader wins the next tie
  logic                game_starved, vga_starved;
  logic [S_ADDR_W-1:0] rd_addr;
  logic [DataW-1:0]    rd_data;
  logic                seg_hit;
  logic                game_valid_q, game_seg_q, vga_valid_q, vga_seg_q;
  logic [X_BITS-1:0]   game_x_q, vga_x_q;
  logic [Y_BITS-1:0]   game_y_q, vga_y_q;

  assign game_starved = game_rd_req && (game_wait_q == StarveMax);
  assign vga_starved  = vga_rd_req && (vga_wait_q == StarveMax);

  always_comb begin
    wr_gnt      = 1'b0;
    game_rd_gnt = 1'b0;
    vga_rd_gnt  = 1'b0;
    if (!sys_reset) begin
      if (game_starved && vga_starved) begin
        if (rr_q) vga_rd_gnt = 1'b1;
        else      game_rd_gnt = 1'b1;
      end else if (game_starved) begin
        game_rd_gnt = 1'b1;
      end else if (vga_starved) begin
        vga_rd_gnt = 1'b1;
      end else if (wr_req) begin
        wr_gnt = 1'b1;
      end else if (game_rd_req && vga_rd_req) begin
        if (rr_q) vga_rd_gnt = 1'b1;
        else      game_rd_gnt = 1'b1;
      end else if (game_rd_req) begin
        game_rd_gnt = 1'b1;
      end else if (vga_rd_req) begin
        vga_rd_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    game_wait_d = game_wait_q;
    vga_wait_d  = vga_wait_q;
    rr_d        = rr_q;
    if (!game_rd_req || game_rd_gnt)   game_wait_d = 4'd0;
    else if (game_wait_q != StarveMax) game_wait_d = game_wait_q + 4'd1;
    if (!vga_rd_req || vga_rd_gnt)     vga_wait_d = 4'd0;
    else if (vga_wait_q != StarveMax)  vga_wait_d = vga_wait_q + 4'd1;
    if (game_rd_gnt)     rr_d = 1'b1;
    else if (vga_rd_gnt) rr_d = 1'b0;
  end

  // Only one reader is granted per cycle, so a single shared read port suffices.
  assign rd_addr = game_rd_gnt ? game_rd_addr : vga_rd_addr;
  assign rd_data = mem[rd_addr];
  assign seg_hit = CmpW'(rd_addr) < CmpW'(snake_length_in);

  always_ff @(posedge sys_clk) begin
    if (wr_gnt) mem[wr_addr] <= {wr_x, wr_y};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      game_wait_q  <= 4'd0;
      vga_wait_q   <= 4'd0;
      rr_q         <= 1'b0;
      game_valid_q <= 1'b0;
      game_seg_q   <= 1'b0;
      game_x_q     <= '0;
      game_y_q     <= '0;
      vga_valid_q  <= 1'b0;
      vga_seg_q    <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
    end else begin
      game_wait_q  <= game_wait_d;
      vga_wait_q   <= vga_wait_d;
      rr_q         <= rr_d;
      game_valid_q <= game_rd_gnt;
      game_seg_q   <= game_rd_gnt && seg_hit;
      vga_valid_q  <= vga_rd_gnt;
      vga_seg_q    <= vga_rd_gnt && seg_hit;
      if (game_rd_gnt) {game_x_q, game_y_q} <= rd_data;
      if (vga_rd_gnt)  {vga_x_q, vga_y_q}   <= rd_data;
    end
  end

  // A read granted just before reset must not surface while reset is held.
  assign game_rd_valid     = game_valid_q && !sys_reset;
  assign game_rd_seg_valid = game_seg_q && !sys_reset;
  assign game_rd_x         = game_x_q;
  assign game_rd_y         = game_y_q;
  assign vga_rd_valid      = vga_valid_q && !sys_reset;
  assign vga_rd_seg_valid  = vga_seg_q && !sys_reset;
  assign vga_rd_x          = vga_x_q;
  assign vga_rd_y          = vga_y_q;

`ifdef SNAKE_ARB_STATS_EN
  logic        stall;
  logic [15:0] stall_cnt_q;

  assign stall = (wr_req && !wr_gnt) || (game_rd_req && !game_rd_gnt) ||
                 (vga_rd_req && !vga_rd_gnt);

  always_ff @(posedge sys_clk) begin
    if (sys_reset || stall_cnt_clr)           stall_cnt_q <= 16'd0;
    else if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cnt_out = stall_cnt_q;
`endif

endmodule
